piso_rr_scheduler: RTL and testbench
====================================

# piso_rr_scheduler

Round-robin scheduler that shares one parallel-in/serial-out serializer (`load`, `parallel`, `serial`, MSB first, one bit per clock) between `NREQ` requesters. It arbitrates pending words and drives the serializer's `load`/`parallel` inputs with exactly `WIDTH`-cycle spacing, so back-to-back frames leave the serializer as a gapless bit stream. It returns a one-cycle `ack` to the winning requester and emits sideband (`ser_valid`, `ser_first`, `ser_src`) cycle-aligned with the serializer's `serial` output. It sits between the requesting blocks and the serializer instance; both share `clk` and `rst`.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `WIDTH`, 4: serializer word width, ≥2; must equal the serializer's width.
- `SW`, derived = $clog2(NREQ): width of the source index.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock, asynchronous active-low reset, shared with the serializer.
- `req`  in  NREQ  per-requester request level; held with data until `ack`.
- `req_data`  in  NREQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH].
- `ack`  out  NREQ  one-hot, one-cycle pulse: word of requester i captured.
- `piso_load`  out  1  to serializer `load`.
- `piso_parallel`  out  WIDTH  to serializer `parallel`.
- `ser_valid`  out  1  high while serializer `serial` carries a granted bit.
- `ser_first`  out  1  high with the MSB of each frame.
- `ser_src`  out  SW  requester index of the bit on `serial`.
- `busy`  out  1  high in LOAD or SHIFT.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset clears state to IDLE, clears counters and the sideband pipeline, and sets the RR pointer to NREQ-1, so requester 0 wins first.
- States:
  - IDLE: if any `req` is sampled, move to LOAD.
  - LOAD: lasts 1 cycle; `piso_load`=1 and `ack[g]`=1; go to SHIFT.
  - SHIFT: lasts WIDTH-1 cycles, counted by `cnt`.
    - On the last SHIFT cycle: if any `req` is sampled, go to LOAD; else go to IDLE.
- Arbitration happens on the edge entering LOAD.
  - Winner g is the first requester with `req` set, searching from pointer+1 upward with wrap at NREQ-1 → 0.
  - On the same edge: `piso_parallel` ← `req_data[g]`, pointer ← g, latched source ← g.
- `piso_parallel` holds its value outside LOAD.
- `req` deassertion rules:
  - A requester drops `req` on the edge after seeing `ack`.
  - A requester sampled in SHIFT that is not granted keeps waiting.
  - Dropping `req` before `ack` is legal: the word is not sent and no `ack` is issued.
- Sideband:
  - `ser_valid` is high for the WIDTH cycles starting 2 cycles after each `piso_load` cycle.
  - `ser_first` is high on the first of those WIDTH cycles only.
  - `ser_src` = the latched g of that frame during those cycles, and holds its value otherwise.
  - On back-to-back frames, `ser_valid` stays high continuously and `ser_first` marks each frame boundary.
- Simultaneous events:
  - If the granted requester re-asserts `req` in the cycle right after `ack`, it is treated as a new word; it competes at the next arbitration at lowest priority.
  - Reset asserted mid-frame aborts the frame immediately: `ser_valid`=0, no `ack`, and the pending word is not retained.

## Timing
- Let cycle n be the period after edge n.
- `req` first sampled at edge 1 (from IDLE):
  - `piso_load`, `ack`, `busy` high in cycle 1.
  - Serializer buffer loads at edge 2.
  - MSB appears on `serial` in cycle 3; `ser_valid` is high in cycles 3..3+WIDTH-1.
- Load spacing is exactly WIDTH cycles when requests are continuous, giving 100% serial utilization.
- Request-to-first-bit latency:
  - From IDLE: 3 cycles.
  - From SHIFT: up to WIDTH-1+3 cycles.
- `busy` drops in the cycle after the last SHIFT cycle when no `req` is sampled.
- `ser_valid` trails `busy` by 2 cycles.

## Test plan
- Reset: hold `rst`=0 with random `req` → all outputs 0. Release `rst` → no `ack` until a `req` is sampled.
- Single word, `req[2]`=1, data 4'b1011 → `ack`=4'b0100 and `piso_load` in the same cycle. Two cycles later `serial` = 1,0,1,1 with `ser_valid`=1 for 4 cycles, `ser_first` on the first cycle, `ser_src`=2.
- Back-to-back, `req[0]` then `req[1]` → `piso_load` pulses exactly 4 cycles apart. `ser_valid` stays high for 8 cycles, `ser_first` is high twice, `ser_src` goes 0 then 1.
- Fairness: all four `req` held continuously (requesters re-present a new word after each `ack`) → grant order 0,1,2,3,0,…; no requester is skipped.
- Reset mid-frame (`rst`=0 in the second shift cycle) → `ser_valid`, `busy`, `ack` go to 0 asynchronously. After release, the RR order restarts at requester 0.
- Withdrawn request: `req[3]` rises during SHIFT and falls before the arbitration edge → no `ack[3]`, and the FSM returns to IDLE.

Source files
------------

// File: rtl/piso_rr_scheduler.sv
// Round-robin front end for a shared parallel-in/serial-out serializer.
// Loads one granted word every WIDTH cycles and tracks serial-side sideband.
module piso_rr_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   parameter int SW    = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         ack,
   output logic                    piso_load,
   output logic [WIDTH-1:0]        piso_parallel,
   output logic                    ser_valid,
   output logic                    ser_first,
   output logic [SW-1:0]           ser_src,
   output logic                    busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 2);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;

   logic [1:0]       state_reg, state_next;
   logic [CW-1:0]    cnt_reg;
   logic [SW-1:0]    ptr_reg;
   logic [SW-1:0]    src_reg;
   logic             load_d_reg;
   logic [CW-1:0]    scnt_reg;

   logic [WIDTH-1:0] word [NREQ];
   logic [SW-1:0]    grant_idx;
   logic             grant_any;
   logic             enter_load;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_word
         assign word[gi] = req_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // First requester above the pointer wins; the pointer itself is searched last.
   always_comb begin
      logic [SW-1:0] cand;
      grant_idx = ptr_reg;
      grant_any = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = SW'((int'(ptr_reg) + i) % NREQ);
         if (!grant_any && req[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_any) state_next = LOAD;
         LOAD:    state_next = SHIFT;
         SHIFT:   if (cnt_reg == CNT_LAST) state_next = grant_any ? LOAD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign enter_load = (state_next == LOAD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         ptr_reg       <= SW'(NREQ - 1);
         src_reg       <= '0;
         ack           <= '0;
         piso_load     <= 1'b0;
         piso_parallel <= '0;
         busy          <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy      <= (state_next != IDLE);
         piso_load <= enter_load;
         ack       <= enter_load ? (NREQ'(1) << grant_idx) : '0;
         cnt_reg   <= (state_reg == SHIFT) ? cnt_reg + 1'b1 : '0;
         if (enter_load) begin
            piso_parallel <= word[grant_idx];
            ptr_reg       <= grant_idx;
            src_reg       <= grant_idx;
         end
      end
   end

   // The serializer captures at the edge after piso_load and presents the MSB one
   // cycle later, so the frame window opens two cycles after the load pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_d_reg <= 1'b0;
         scnt_reg   <= '0;
         ser_valid  <= 1'b0;
         ser_first  <= 1'b0;
         ser_src    <= '0;
      end else begin
         load_d_reg <= piso_load;
         if (load_d_reg) begin
            ser_valid <= 1'b1;
            ser_first <= 1'b1;
            ser_src   <= src_reg;
            scnt_reg  <= CW'(WIDTH - 1);
         end else if (scnt_reg != '0) begin
            ser_valid <= 1'b1;
            ser_first <= 1'b0;
            scnt_reg  <= scnt_reg - 1'b1;
         end else begin
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_piso_rr_scheduler.sv
// Directed bench for piso_rr_scheduler with a behavioural 4-bit serializer attached.
module tb_piso_rr_scheduler;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic [3:0]  ack;
   logic        piso_load;
   logic [3:0]  piso_parallel;
   logic        ser_valid;
   logic        ser_first;
   logic [1:0]  ser_src;
   logic        busy;

   logic [3:0]  sbuf;
   logic        serial;

   int checks;
   int errors;

   piso_rr_scheduler #(.NREQ(4), .WIDTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_data      (req_data),
      .ack           (ack),
      .piso_load     (piso_load),
      .piso_parallel (piso_parallel),
      .ser_valid     (ser_valid),
      .ser_first     (ser_first),
      .ser_src       (ser_src),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Serializer: captures on load, shifts MSB first through a registered output.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sbuf   <= 4'b0;
         serial <= 1'b0;
      end else begin
         serial <= sbuf[3];
         sbuf   <= piso_load ? piso_parallel : {sbuf[2:0], 1'b0};
      end
   end

   task automatic test_reset;
      rst = 1'b0;
      req = 4'($urandom);
      req_data = 16'($urandom);
      repeat (2) @(negedge clk);
      checks++;
      if ({ack, piso_load, piso_parallel, ser_valid, ser_first, ser_src, busy} !== 14'b0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%b load=%b par=%b valid=%b first=%b src=%0d busy=%b, required all 0",
                  ack, piso_load, piso_parallel, ser_valid, ser_first, ser_src, busy);
      end
      rst = 1'b1;
      req = 4'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (ack !== 4'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: ack=%b busy=%b, required 0000/0", ack, busy);
      end
      $display("test_reset done");
   endtask

   task automatic test_single;
      logic [3:0] bits;
      bits = 4'b1011;
      req_data = 16'h0;
      req_data[8 +: 4] = bits;
      req = 4'b0100;
      @(negedge clk);
      checks++;
      if (ack !== 4'b0100 || piso_load !== 1'b1 || busy !== 1'b1 || piso_parallel !== bits) begin
         errors++;
         $display("FAIL single_load: ack=%b load=%b busy=%b par=%b, required 0100/1/1/1011",
                  ack, piso_load, busy, piso_parallel);
      end
      req = 4'b0;
      @(negedge clk);
      checks++;
      if (piso_load !== 1'b0 || ack !== 4'b0 || ser_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_cycle2: load=%b ack=%b valid=%b, required 0/0000/0", piso_load, ack, ser_valid);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (ser_valid !== 1'b1 || ser_first !== (k == 0) || ser_src !== 2'd2 ||
             serial !== bits[3-k] || busy !== (k < 2)) begin
            errors++;
            $display("FAIL single_bit%0d: valid=%b first=%b src=%0d serial=%b busy=%b, required 1/%0d/2/%b/%0d",
                     k, ser_valid, ser_first, ser_src, serial, busy, (k == 0), bits[3-k], (k < 2));
         end
      end
      @(negedge clk);
      checks++;
      if (ser_valid !== 1'b0 || piso_parallel !== bits || ser_src !== 2'd2) begin
         errors++;
         $display("FAIL single_end: valid=%b par=%b src=%0d, required 0/1011/2", ser_valid, piso_parallel, ser_src);
      end
      $display("test_single done");
   endtask

   task automatic test_back_to_back;
      logic [7:0] stream;
      logic [3:0] exp_ack;
      stream = 8'b0110_1100;
      req_data = 16'h0;
      req_data[0 +: 4] = stream[7:4];
      req_data[4 +: 4] = stream[3:0];
      req = 4'b0011;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         exp_ack = (c == 1) ? 4'b0001 : (c == 5) ? 4'b0010 : 4'b0000;
         checks++;
         if (ack !== exp_ack || piso_load !== (c == 1 || c == 5)) begin
            errors++;
            $display("FAIL b2b_load_c%0d: ack=%b load=%b, required %b/%0d", c, ack, piso_load, exp_ack, (c == 1 || c == 5));
         end
         if (c >= 3) begin
            checks++;
            if (ser_valid !== (c <= 10) || ser_first !== (c == 3 || c == 7) ||
                ser_src !== ((c < 7) ? 2'd0 : 2'd1) || (c <= 10 && serial !== stream[10-c])) begin
               errors++;
               $display("FAIL b2b_serial_c%0d: valid=%b first=%b src=%0d serial=%b, required %0d/%0d/%0d/%b",
                        c, ser_valid, ser_first, ser_src, serial, (c <= 10), (c == 3 || c == 7),
                        (c < 7) ? 0 : 1, (c <= 10) ? stream[10-c] : 1'b0);
            end
         end
         if (c == 1) req = 4'b0010;
         if (c == 5) req = 4'b0000;
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_fairness;
      logic [3:0] exp_ack;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      req_data = 16'h8421;
      req = 4'b1111;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         exp_ack = ((c - 1) % 4 == 0) ? (4'b0001 << (((c - 1) / 4) % 4)) : 4'b0000;
         checks++;
         if (ack !== exp_ack || piso_load !== ((c - 1) % 4 == 0) || (c >= 3 && ser_valid !== 1'b1)) begin
            errors++;
            $display("FAIL fair_c%0d: ack=%b load=%b valid=%b, required %b/%0d/%0d",
                     c, ack, piso_load, ser_valid, exp_ack, ((c - 1) % 4 == 0), (c >= 3));
         end
         req_data = ~req_data;
      end
      req = 4'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ser_valid !== 1'b0) begin
         errors++;
         $display("FAIL fair_drain: busy=%b valid=%b, required 0/0", busy, ser_valid);
      end
      $display("test_fairness done");
   endtask

   task automatic test_reset_mid_frame;
      req_data = 16'h0009;
      req = 4'b0001;
      @(negedge clk);
      checks++;
      if (ack !== 4'b0001) begin
         errors++;
         $display("FAIL midrst_first_ack: ack=%b, required 0001", ack);
      end
      req = 4'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (ser_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midrst_active: valid=%b busy=%b, required 1/1", ser_valid, busy);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (ser_valid !== 1'b0 || busy !== 1'b0 || ack !== 4'b0 || piso_load !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async: valid=%b busy=%b ack=%b load=%b, required 0/0/0000/0",
                  ser_valid, busy, ack, piso_load);
      end
      @(negedge clk);
      rst = 1'b1;
      req = 4'b0011;
      @(negedge clk);
      checks++;
      if (ack !== 4'b0001) begin
         errors++;
         $display("FAIL midrst_restart: ack=%b, required 0001", ack);
      end
      req = 4'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ser_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_drain: busy=%b valid=%b, required 0/0", busy, ser_valid);
      end
      $display("test_reset_mid_frame done");
   endtask

   task automatic test_withdrawn;
      req_data = 16'h5003;
      req = 4'b0001;
      @(negedge clk);
      checks++;
      if (ack !== 4'b0001) begin
         errors++;
         $display("FAIL withdraw_ack0: ack=%b, required 0001", ack);
      end
      req = 4'b0;
      for (int c = 2; c <= 9; c++) begin
         @(negedge clk);
         checks++;
         if (ack !== 4'b0 || piso_load !== 1'b0 || busy !== (c <= 4)) begin
            errors++;
            $display("FAIL withdraw_c%0d: ack=%b load=%b busy=%b, required 0000/0/%0d",
                     c, ack, piso_load, busy, (c <= 4));
         end
         if (c == 2) req = 4'b1000;
         if (c == 3) req = 4'b0000;
      end
      $display("test_withdrawn done");
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b0;
      req      = 4'b0;
      req_data = 16'h0;
      test_reset();
      test_single();
      test_back_to_back();
      test_fairness();
      test_reset_mid_frame();
      test_withdrawn();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
